// File: rtl/status_sticky_capture.sv
// Sticky status capture stage: latches synchronized status bits (per-bit level or
// rising-edge), W1C clear, masked interrupt, saturating event count and first-event index.
module status_sticky_capture #(
  parameter int DATA_WIDTH = 1,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] status_in,
  input  logic [DATA_WIDTH-1:0] edge_mode,
  input  logic                  clr_en,
  input  logic [DATA_WIDTH-1:0] clr_mask,
  input  logic [DATA_WIDTH-1:0] irq_mask,
  input  logic                  cnt_clr,
  output logic [DATA_WIDTH-1:0] sticky_out,
  output logic                  irq,
  output logic [CNT_WIDTH-1:0]  event_cnt,
  output logic                  first_valid,
  output logic [IDX_WIDTH-1:0]  first_idx
);

  localparam int POP_W = $clog2(DATA_WIDTH + 1);
  localparam int SUM_W = ((CNT_WIDTH > POP_W) ? CNT_WIDTH : POP_W) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [SUM_W-1:0]     CNT_MAX_EXT = SUM_W'(CNT_MAX);

  typedef enum logic [1:0] {ST_RST, ST_ARM, ST_RUN} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] prev_reg;
  logic [DATA_WIDTH-1:0] set_vec;
  logic [DATA_WIDTH-1:0] clr_vec;
  logic [DATA_WIDTH-1:0] sticky_next;
  logic [DATA_WIDTH-1:0] new_vec;
  logic [POP_W-1:0]      new_count;
  logic                  any_new;
  logic [IDX_WIDTH-1:0]  new_idx;
  logic [SUM_W-1:0]      cnt_base;
  logic [SUM_W-1:0]      cnt_sum;
  logic [CNT_WIDTH-1:0]  cnt_next;

  // Only bits that were not already sticky count as new events; a bit held
  // high in level mode therefore counts once until it drops and is cleared.
  always_comb begin
    set_vec = '0;
    if (state == ST_RUN)
      set_vec = (status_in & ~prev_reg & edge_mode) | (status_in & ~edge_mode);
    clr_vec     = clr_en ? clr_mask : '0;
    sticky_next = (sticky_out & ~clr_vec) | set_vec;
    new_vec     = set_vec & ~sticky_out;

    new_count = '0;
    any_new   = 1'b0;
    new_idx   = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      new_count = new_count + POP_W'(new_vec[i]);
      if (new_vec[i]) begin
        any_new = 1'b1;
        new_idx = IDX_WIDTH'(i);
      end
    end

    cnt_base = cnt_clr ? '0 : SUM_W'(event_cnt);
    cnt_sum  = cnt_base + SUM_W'(new_count);
    cnt_next = (cnt_sum > CNT_MAX_EXT) ? CNT_MAX : cnt_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RST;
      prev_reg    <= '0;
      sticky_out  <= '0;
      irq         <= 1'b0;
      event_cnt   <= '0;
      first_valid <= 1'b0;
      first_idx   <= '0;
    end else begin
      case (state)
        ST_RST: state <= ST_ARM;
        ST_ARM: begin
          state    <= ST_RUN;
          prev_reg <= status_in;
        end
        ST_RUN: prev_reg <= status_in;
        default: state <= ST_RST;
      endcase

      sticky_out <= sticky_next;
      irq        <= |(sticky_next & irq_mask);
      event_cnt  <= cnt_next;

      // cnt_clr restarts first-event capture from this same cycle's events
      if (cnt_clr) begin
        first_valid <= any_new;
        first_idx   <= any_new ? new_idx : '0;
      end else if (!first_valid && any_new) begin
        first_valid <= 1'b1;
        first_idx   <= new_idx;
      end
    end
  end

endmodule

// File: tb/tb_status_sticky_capture.sv
// Directed bench for status_sticky_capture: a 4-bit instance with a wide counter and
// a 4-bit instance with a 2-bit counter share stimulus; expected values are hand-computed.
module tb_status_sticky_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] status_in;
  logic [3:0] edge_mode;
  logic       clr_en;
  logic [3:0] clr_mask;
  logic [3:0] irq_mask;
  logic       cnt_clr;

  logic [3:0]  sticky_out, sticky_n;
  logic        irq, irq_n;
  logic [15:0] event_cnt;
  logic [1:0]  event_cnt_n;
  logic        first_valid, first_valid_n;
  logic [1:0]  first_idx, first_idx_n;

  int checks   = 0;
  int failures = 0;

  status_sticky_capture #(.DATA_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .status_in(status_in), .edge_mode(edge_mode),
    .clr_en(clr_en), .clr_mask(clr_mask), .irq_mask(irq_mask), .cnt_clr(cnt_clr),
    .sticky_out(sticky_out), .irq(irq), .event_cnt(event_cnt),
    .first_valid(first_valid), .first_idx(first_idx)
  );

  status_sticky_capture #(.DATA_WIDTH(4), .CNT_WIDTH(2)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .status_in(status_in), .edge_mode(edge_mode),
    .clr_en(clr_en), .clr_mask(clr_mask), .irq_mask(irq_mask), .cnt_clr(cnt_clr),
    .sticky_out(sticky_n), .irq(irq_n), .event_cnt(event_cnt_n),
    .first_valid(first_valid_n), .first_idx(first_idx_n)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] sts, input logic [3:0] edg,
                               input logic ce, input logic [3:0] cm,
                               input logic [3:0] im, input logic cc);
    status_in = sts;
    edge_mode = edg;
    clr_en    = ce;
    clr_mask  = cm;
    irq_mask  = im;
    cnt_clr   = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'h3, 4'hF, 1'b0, 4'h0, 4'h4, 1'b0);
    applyStimulus(4'h3, 4'hF, 1'b0, 4'h0, 4'h4, 1'b0);
    checkOutput("rst_sticky", 32'(sticky_out), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_cnt", 32'(event_cnt), 32'h0);
    checkOutput("rst_fvalid", 32'(first_valid), 32'h0);
    checkOutput("rst_fidx", 32'(first_idx), 32'h0);
    checkOutput("rst_cnt_narrow", 32'(event_cnt_n), 32'h0);

    // Release with bits already high: no false edges
    rst_n = 1'b1;
    applyStimulus(4'h3, 4'hF, 1'b0, 4'h0, 4'h4, 1'b0);
    applyStimulus(4'h3, 4'hF, 1'b0, 4'h0, 4'h4, 1'b0);
    checkOutput("arm_sticky", 32'(sticky_out), 32'h0);
    applyStimulus(4'h3, 4'hF, 1'b0, 4'h0, 4'h4, 1'b0);
    checkOutput("run_no_false_edge", 32'(sticky_out), 32'h0);
    checkOutput("run_no_false_cnt", 32'(event_cnt), 32'h0);

    applyStimulus(4'h7, 4'hF, 1'b0, 4'h0, 4'h4, 1'b0);
    checkOutput("bit2_sticky", 32'(sticky_out), 32'h4);
    checkOutput("bit2_cnt", 32'(event_cnt), 32'h1);
    checkOutput("bit2_fvalid", 32'(first_valid), 32'h1);
    checkOutput("bit2_fidx", 32'(first_idx), 32'h2);
    checkOutput("bit2_irq", 32'(irq), 32'h1);
    checkOutput("bit2_cnt_narrow", 32'(event_cnt_n), 32'h1);

    // Bit0 switched to level mode while high
    applyStimulus(4'h7, 4'hE, 1'b0, 4'h0, 4'h1, 1'b0);
    checkOutput("lvl_sticky", 32'(sticky_out), 32'h5);
    checkOutput("lvl_cnt", 32'(event_cnt), 32'h2);
    checkOutput("lvl_irq", 32'(irq), 32'h1);
    checkOutput("lvl_fidx_held", 32'(first_idx), 32'h2);
    applyStimulus(4'h7, 4'hE, 1'b0, 4'h0, 4'h1, 1'b0);
    checkOutput("lvl_hold_cnt", 32'(event_cnt), 32'h2);
    applyStimulus(4'h7, 4'hE, 1'b1, 4'h1, 4'h1, 1'b0);
    checkOutput("lvl_clr_reset_sticky", 32'(sticky_out), 32'h5);
    checkOutput("lvl_clr_reset_cnt", 32'(event_cnt), 32'h2);
    checkOutput("lvl_clr_reset_irq", 32'(irq), 32'h1);
    applyStimulus(4'h6, 4'hE, 1'b0, 4'h0, 4'h1, 1'b0);
    applyStimulus(4'h6, 4'hE, 1'b1, 4'h1, 4'h1, 1'b0);
    checkOutput("w1c_sticky", 32'(sticky_out), 32'h4);
    checkOutput("w1c_irq", 32'(irq), 32'h0);
    applyStimulus(4'h7, 4'hE, 1'b0, 4'h0, 4'h1, 1'b0);
    checkOutput("lvl_again_sticky", 32'(sticky_out), 32'h5);
    checkOutput("lvl_again_cnt", 32'(event_cnt), 32'h3);
    checkOutput("lvl_again_irq", 32'(irq), 32'h1);
    checkOutput("lvl_again_cnt_narrow", 32'(event_cnt_n), 32'h3);

    // Edge on bit1, then a second edge coinciding with its clear
    applyStimulus(4'h5, 4'hE, 1'b0, 4'h0, 4'h1, 1'b0);
    applyStimulus(4'h7, 4'hE, 1'b0, 4'h0, 4'h1, 1'b0);
    checkOutput("edge1_sticky", 32'(sticky_out), 32'h7);
    checkOutput("edge1_cnt", 32'(event_cnt), 32'h4);
    checkOutput("edge1_cnt_narrow_sat", 32'(event_cnt_n), 32'h3);
    applyStimulus(4'h5, 4'hE, 1'b0, 4'h0, 4'h1, 1'b0);
    applyStimulus(4'h7, 4'hE, 1'b1, 4'h2, 4'h1, 1'b0);
    checkOutput("set_wins_sticky", 32'(sticky_out), 32'h7);
    checkOutput("set_wins_cnt", 32'(event_cnt), 32'h4);

    // Full clear plus cnt_clr with no new events
    applyStimulus(4'h5, 4'hE, 1'b1, 4'hF, 4'h1, 1'b1);
    checkOutput("cclr_sticky", 32'(sticky_out), 32'h1);
    checkOutput("cclr_cnt", 32'(event_cnt), 32'h0);
    checkOutput("cclr_cnt_narrow", 32'(event_cnt_n), 32'h0);
    checkOutput("cclr_fvalid", 32'(first_valid), 32'h0);
    checkOutput("cclr_fidx", 32'(first_idx), 32'h0);

    // Bits 3 and 1 rise together: lowest index wins
    applyStimulus(4'hF, 4'hE, 1'b0, 4'h0, 4'h8, 1'b0);
    checkOutput("dual_sticky", 32'(sticky_out), 32'hB);
    checkOutput("dual_cnt", 32'(event_cnt), 32'h2);
    checkOutput("dual_fvalid", 32'(first_valid), 32'h1);
    checkOutput("dual_fidx", 32'(first_idx), 32'h1);
    checkOutput("dual_irq", 32'(irq), 32'h1);
    applyStimulus(4'hF, 4'hE, 1'b0, 4'h0, 4'h0, 1'b0);
    checkOutput("mask_off_irq", 32'(irq), 32'h0);
    checkOutput("mask_off_sticky", 32'(sticky_out), 32'hB);

    // Four simultaneous events: narrow counter saturates
    applyStimulus(4'h0, 4'hE, 1'b1, 4'hB, 4'hF, 1'b0);
    checkOutput("allclr_sticky", 32'(sticky_out), 32'h0);
    checkOutput("allclr_irq", 32'(irq), 32'h0);
    applyStimulus(4'hF, 4'hE, 1'b0, 4'h0, 4'hF, 1'b0);
    checkOutput("quad_sticky", 32'(sticky_out), 32'hF);
    checkOutput("quad_cnt", 32'(event_cnt), 32'h6);
    checkOutput("quad_cnt_narrow_sat", 32'(event_cnt_n), 32'h3);
    checkOutput("quad_fidx_held", 32'(first_idx), 32'h1);

    // cnt_clr alongside a single new event on bit2
    applyStimulus(4'hB, 4'hE, 1'b1, 4'h4, 4'hF, 1'b0);
    checkOutput("pre_cclr_sticky", 32'(sticky_out), 32'hB);
    applyStimulus(4'hF, 4'hE, 1'b0, 4'h0, 4'hF, 1'b1);
    checkOutput("cclr_evt_cnt", 32'(event_cnt), 32'h1);
    checkOutput("cclr_evt_cnt_narrow", 32'(event_cnt_n), 32'h1);
    checkOutput("cclr_evt_fvalid", 32'(first_valid), 32'h1);
    checkOutput("cclr_evt_fidx", 32'(first_idx), 32'h2);
    checkOutput("cclr_evt_sticky", 32'(sticky_out), 32'hF);

    // Mid-run reset, then a level bit detected only from the first RUN cycle
    rst_n = 1'b0;
    applyStimulus(4'hF, 4'h7, 1'b0, 4'h0, 4'hF, 1'b0);
    checkOutput("mrst_sticky", 32'(sticky_out), 32'h0);
    checkOutput("mrst_irq", 32'(irq), 32'h0);
    checkOutput("mrst_cnt", 32'(event_cnt), 32'h0);
    checkOutput("mrst_cnt_narrow", 32'(event_cnt_n), 32'h0);
    checkOutput("mrst_fvalid", 32'(first_valid), 32'h0);
    rst_n = 1'b1;
    applyStimulus(4'hF, 4'h7, 1'b0, 4'h0, 4'hF, 1'b0);
    checkOutput("mrst_rel_sticky", 32'(sticky_out), 32'h0);
    applyStimulus(4'hF, 4'h7, 1'b0, 4'h0, 4'hF, 1'b0);
    checkOutput("mrst_arm_sticky", 32'(sticky_out), 32'h0);
    checkOutput("mrst_arm_irq", 32'(irq), 32'h0);
    applyStimulus(4'hF, 4'h7, 1'b0, 4'h0, 4'hF, 1'b0);
    checkOutput("mrst_run_sticky", 32'(sticky_out), 32'h8);
    checkOutput("mrst_run_cnt", 32'(event_cnt), 32'h1);
    checkOutput("mrst_run_fidx", 32'(first_idx), 32'h3);
    checkOutput("mrst_run_irq", 32'(irq), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
